// File: rtl/noc_tx_ni.sv
// Transmit network interface: PE valid/ready in, FIFO, then a
// four-phase bundled-data req/ack handshake into a router proc_in port.
module noc_tx_ni #(
  parameter int PAYLOAD = 4,
  parameter int X_BITS  = 1,
  parameter int Y_BITS  = 1,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [X_BITS-1:0]                 in_dest_x,
  input  logic [Y_BITS-1:0]                 in_dest_y,
  input  logic [PAYLOAD-1:0]                in_payload,
  output logic                              noc_req,
  output logic [X_BITS+Y_BITS+PAYLOAD-1:0]  noc_data,
  input  logic                              noc_ack,
  output logic                              busy,
  output logic [CNT_W-1:0]                  tx_count
);

  localparam int PACKET_SIZE = X_BITS + Y_BITS + PAYLOAD;
  localparam int AW          = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    REQ,
    RELEASE
  } state_t;

  logic [PACKET_SIZE-1:0] mem [DEPTH];
  logic [AW:0]            wr_ptr;
  logic [AW:0]            rd_ptr;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;
  logic                   load;
  logic                   inc;
  logic                   req_d;
  logic                   ack_q;
  logic                   ack_s;
  state_t                 state;
  state_t                 state_d;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign busy     = !empty || (state != IDLE);

  // FIFO storage; contents need no reset, emptiness lives in the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {in_dest_x, in_dest_y, in_payload};
    end
  end

  // FIFO pointers with an extra wrap bit to tell full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // two-flop synchroniser for the router's asynchronous ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_q <= noc_ack;
      ack_s <= ack_q;
    end
  end

  // handshake sequencing; data is captured on entry to LOAD so it
  // settles a full cycle before req rises
  always_comb begin
    state_d = state;
    req_d   = noc_req;
    pop     = 1'b0;
    load    = 1'b0;
    inc     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && !ack_s) begin
          state_d = LOAD;
          load    = 1'b1;
        end
      end
      LOAD: begin
        pop     = 1'b1;
        req_d   = 1'b1;
        state_d = REQ;
      end
      REQ: begin
        if (ack_s) begin
          req_d   = 1'b0;
          inc     = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!ack_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // registered FSM state and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      noc_req  <= 1'b0;
      noc_data <= '0;
      tx_count <= '0;
    end else begin
      state   <= state_d;
      noc_req <= req_d;
      if (load) noc_data <= mem[rd_ptr[AW-1:0]];
      if (inc)  tx_count <= tx_count + CNT_W'(1);
    end
  end

endmodule
